// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the prefetching instruction-fetch unit.
// Holds the FSM state encoding and the default bus widths.
package ifetch_queue_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_queue_fetch_fifo.sv
// Synchronous FIFO holding fetched {instruction, pc} pairs.
// Flush wins over push/pop; the head reads zero while the FIFO is empty.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign count_o = count_q;
  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the empty-gated head hides stale contents.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Prefetching fetch unit: runs the mem_en/mfc handshake and queues {word, pc}.
// Redirect flushes the queue; an in-flight response is drained and dropped.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mfc,
  output logic              ins_valid,
  output logic [DATA_W-1:0] ins_data,
  output logic [ADDR_W-1:0] ins_pc,
  input  logic              ins_ready,
  output logic [CW-1:0]     ins_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_en_q, mem_en_d;
  logic              push, pop, room;

  assign ins_valid = (ins_count != '0);
  assign pop       = ins_valid && ins_ready && !redirect;
  // A request only goes out when its response is sure to find a free slot.
  assign room      = (ins_count < CW'(DEPTH)) || pop;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_en_d   = mem_en_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    if (redirect) fetch_pc_d = redirect_pc;
    case (state_q)
      IDLE: begin
        if (!redirect && room) begin
          state_d    = WAIT;
          mem_en_d   = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
      end
      WAIT: begin
        if (mfc) begin
          state_d  = IDLE;
          mem_en_d = 1'b0;
          if (!redirect) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
          end
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (mfc) begin
          state_d  = IDLE;
          mem_en_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_en_q   <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  fetch_fifo #(
    .W     (DATA_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .data_i  ({mem_rdata, mem_addr_q}),
    .head_o  ({ins_data, ins_pc}),
    .count_o (ins_count)
  );

endmodule
